// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath and the memory responder.
// The master holds Read or Write high until it sees Done; Done stays high until both strobes are low.
interface mem_responder_if;
  logic        Read;
  logic        Write;
  logic [31:0] MAR_Data;
  logic [31:0] MDR_Data;
  logic [31:0] Mdatain;
  logic        Done;
  logic        busy;
  logic        err;

  modport master (
    output Read, Write, MAR_Data, MDR_Data,
    input  Mdatain, Done, busy, err
  );

  modport slave (
    input  Read, Write, MAR_Data, MDR_Data,
    output Mdatain, Done, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with configurable wait states, a 4-phase Done
// handshake and error reporting for out-of-range addresses or conflicting strobes.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            clr,
  mem_responder_if.slave  bus,
  output logic [1:0]      dbg_state
);

  localparam int          DEPTH = 2 ** ADDR_W;
  localparam logic [3:0]  WS4   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       mem [DEPTH];
  logic              op_wr;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_data;
  logic [3:0]        cnt;
  logic              req_one;
  logic              req_both;
  logic              strobes_low;
  logic              addr_bad;
  logic [ADDR_W-1:0] word_addr;

  assign req_one     = bus.Read ^ bus.Write;
  assign req_both    = bus.Read & bus.Write;
  assign strobes_low = ~bus.Read & ~bus.Write;
  assign addr_bad    = (lat_addr[31:ADDR_W] != '0);
  assign word_addr   = lat_addr[ADDR_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_both)
          state_nxt = S_HOLD;
        else if (req_one)
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT:   if (cnt == 4'd1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_HOLD;
      S_HOLD:   if (strobes_low) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_wr       <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      cnt         <= '0;
      bus.Mdatain <= '0;
      bus.Done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_one) begin
            op_wr    <= bus.Write;
            lat_addr <= bus.MAR_Data;
            lat_data <= bus.MDR_Data;
            cnt      <= WS4;
          end else if (req_both) begin
            // Conflicting strobes complete immediately as an error; nothing is accessed.
            bus.Done <= 1'b1;
            bus.err  <= 1'b1;
          end
        end
        S_WAIT: cnt <= cnt - 4'd1;
        S_ACCESS: begin
          bus.Done <= 1'b1;
          if (addr_bad) begin
            bus.err     <= 1'b1;
            bus.Mdatain <= '0;
          end else if (!op_wr) begin
            bus.Mdatain <= mem[word_addr];
          end
        end
        S_HOLD: begin
          if (strobes_low) begin
            bus.Done <= 1'b0;
            bus.err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The array has no reset so clr never disturbs stored contents.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && op_wr && !addr_bad)
      mem[word_addr] <= lat_data;
  end

  assign bus.busy  = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized transaction-level check of mem_responder against a memory-array model.
module tb_mem_responder;
  localparam int WS     = 2;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic       clk;
  logic       clr;
  logic [1:0] dbg_state;

  mem_responder_if bus ();

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_mdat;
  logic [31:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one request: returns expected err and latency, queues expected Mdatain.
  task automatic model_req(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, output bit exp_err, output int exp_lat);
    bit in_range;
    in_range = (addr >> ADDR_W) == 0;
    if (rd && wr) begin
      exp_err = 1'b1;
      exp_lat = 0;
    end else begin
      exp_lat = WS + 1;
      exp_err = !in_range;
      if (!in_range)
        model_mdat = 32'h0;
      else if (wr)
        model_mem[addr[ADDR_W-1:0]] = data;
      else
        model_mdat = model_mem[addr[ADDR_W-1:0]];
    end
    exp_q.push_back(model_mdat);
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold_extra);
    bit          exp_err;
    int          exp_lat;
    int          n;
    logic [31:0] exp_d;
    @(negedge clk);
    bus.Read     = rd;
    bus.Write    = wr;
    bus.MAR_Data = addr;
    bus.MDR_Data = data;
    model_req(rd, wr, addr, data, exp_err, exp_lat);
    @(posedge clk); #1;
    // Latched values must be used, so scramble the bus after the request edge.
    bus.MAR_Data = $urandom;
    bus.MDR_Data = $urandom;
    n = 0;
    while (!bus.Done && n < 64) begin
      check_val("busy_wait", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    check_val("latency", n, exp_lat);
    exp_d = exp_q.pop_front();
    check_val("err", 32'(bus.err), 32'(exp_err));
    check_val("mdatain", bus.Mdatain, exp_d);
    check_val("busy_done", 32'(bus.busy), 32'd1);
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk); #1;
      check_val("hold_done", 32'(bus.Done), 32'd1);
      check_val("hold_mdatain", bus.Mdatain, exp_d);
    end
    @(negedge clk);
    bus.Read  = 1'b0;
    bus.Write = 1'b0;
    @(posedge clk); #1;
    check_val("release_done", 32'(bus.Done), 32'd0);
    check_val("release_err", 32'(bus.err), 32'd0);
    check_val("release_busy", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.Read     = 1'b0;
    bus.Write    = 1'b0;
    bus.MAR_Data = '0;
    bus.MDR_Data = '0;
    model_mdat   = 32'h0;
    clr          = 1'b1;
    #12;
    check_val("rst_mdatain", bus.Mdatain, 32'h0);
    check_val("rst_done", 32'(bus.Done), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    clr = 1'b0;

    // Fill every word so later reads have defined contents.
    for (int a = 0; a < DEPTH; a++)
      do_req(1'b0, 1'b1, 32'(a), $urandom, 0);
    do_req(1'b0, 1'b1, 32'h1FF, 32'hDEADBEEF, 0);

    // Write then read back.
    do_req(1'b0, 1'b1, 32'd5, 32'h12345678, 0);
    do_req(1'b1, 1'b0, 32'd5, 32'h0, 0);
    // Top address, Read held extra cycles: no retrigger.
    do_req(1'b1, 1'b0, 32'h1FF, 32'h0, 4);
    // Out-of-range read and write, then confirm mem[0] untouched.
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 0);
    do_req(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 0);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 0);
    // Conflicting strobes, then confirm target untouched.
    do_req(1'b1, 1'b0, 32'd7, 32'h0, 0);
    do_req(1'b1, 1'b1, 32'd7, 32'h0BADBAD0, 2);
    do_req(1'b1, 1'b0, 32'd7, 32'h0, 0);

    // Write aborted by clr shortly after the request edge.
    @(negedge clk);
    bus.Write    = 1'b1;
    bus.MAR_Data = 32'd3;
    bus.MDR_Data = 32'hA5A5A5A5;
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_done", 32'(bus.Done), 32'd0);
    bus.Write = 1'b0;
    #1;
    clr = 1'b0;
    model_mdat = 32'h0;
    do_req(1'b1, 1'b0, 32'd3, 32'h0, 0);

    // Async reset asserted mid-cycle while in HOLD.
    @(negedge clk);
    bus.Read     = 1'b1;
    bus.MAR_Data = 32'd9;
    for (int i = 0; i < WS + 3; i++) @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    check_val("midrst_mdatain", bus.Mdatain, 32'h0);
    check_val("midrst_done", 32'(bus.Done), 32'd0);
    check_val("midrst_busy", 32'(bus.busy), 32'd0);
    check_val("midrst_err", 32'(bus.err), 32'd0);
    bus.Read = 1'b0;
    #1;
    clr = 1'b0;
    model_mdat = 32'h0;

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      int          kind;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      addr = 32'($urandom_range(0, DEPTH - 1));
      if (kind == 0)
        addr = addr | (32'h1 << $urandom_range(ADDR_W, 31));
      if (kind == 1)
        do_req(1'b1, 1'b1, addr, $urandom, $urandom_range(0, 2));
      else if (kind < 6)
        do_req(1'b0, 1'b1, addr, $urandom, $urandom_range(0, 2));
      else
        do_req(1'b1, 1'b0, addr, 32'h0, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
